// File: rtl/serial_word_assembler.sv
// Assembles framed MSB-first serial bits into WIDTH-bit words with optional parity check.
// A good word is presented on WORD with a one-cycle WORD_ENA; bad frames only raise error pulses.
module serial_word_assembler #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BIT_VALID,
    input  logic             BIT_DATA,
    input  logic             FRAME,
    output logic [WIDTH-1:0] WORD,
    output logic             WORD_ENA,
    output logic             PAR_ERR,
    output logic             FRAME_ERR,
    output logic             BUSY
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned TmoW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StData = 2'd1;
    localparam logic [1:0] StPar  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_ena_q, word_ena_d;
    logic             par_err_q, par_err_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] shift_next;
    logic             accept;
    logic             abort;
    logic             tmo_hit;

    assign shift_next = {shift_q[WIDTH-2:0], BIT_DATA};
    assign accept     = BIT_VALID && FRAME;
    assign abort      = BIT_VALID && !FRAME;
    assign tmo_hit    = (TIMEOUT != 0) && (tmo_q == TmoLast);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        word_d      = word_q;
        word_ena_d  = 1'b0;
        par_err_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = {{(WIDTH - 1){1'b0}}, BIT_DATA};
                    cnt_d   = CntW'(1);
                    tmo_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (accept) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + CntW'(1);
                    tmo_d   = '0;
                    if (cnt_q == CntLast) begin
                        if (PARITY_EN) begin
                            state_d = StPar;
                        end else begin
                            // Word is published on entry to DONE so it is visible with the strobe.
                            word_d     = shift_next;
                            word_ena_d = 1'b1;
                            state_d    = StDone;
                        end
                    end
                end else if (abort || tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StPar: begin
                if (accept) begin
                    tmo_d = '0;
                    if ((^{shift_q, BIT_DATA}) == PARITY_ODD) begin
                        word_d     = shift_q;
                        word_ena_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        par_err_d = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (abort || tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StIdle) begin
            cnt_d = '0;
            tmo_d = '0;
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            word_q      <= '0;
            word_ena_q  <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            word_q      <= word_d;
            word_ena_q  <= word_ena_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign WORD      = word_q;
    assign WORD_ENA  = word_ena_q;
    assign PAR_ERR   = par_err_q;
    assign FRAME_ERR = frame_err_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler: one parity build and one no-parity build,
// both with an 8-cycle inter-bit timeout, sharing the same serial input.
module tb_serial_word_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid;
    logic        bit_data;
    logic        frame;
    logic [15:0] word;
    logic        word_ena;
    logic        par_err;
    logic        frame_err;
    logic        busy;
    logic [15:0] np_word;
    logic        np_word_ena;
    logic        np_par_err;
    logic        np_frame_err;
    logic        np_busy;

    logic [15:0] dreg;
    int          ena_cnt = 0;
    int          par_cnt = 0;
    int          ferr_cnt = 0;
    int          np_ena_cnt = 0;
    int          checks = 0;
    int          passes = 0;

    serial_word_assembler #(
        .WIDTH(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .TIMEOUT(8)
    ) dut (
        .CLK(clk), .RST(rst), .BIT_VALID(bit_valid), .BIT_DATA(bit_data), .FRAME(frame),
        .WORD(word), .WORD_ENA(word_ena), .PAR_ERR(par_err), .FRAME_ERR(frame_err),
        .BUSY(busy)
    );

    serial_word_assembler #(
        .WIDTH(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .TIMEOUT(8)
    ) dut_np (
        .CLK(clk), .RST(rst), .BIT_VALID(bit_valid), .BIT_DATA(bit_data), .FRAME(frame),
        .WORD(np_word), .WORD_ENA(np_word_ena), .PAR_ERR(np_par_err),
        .FRAME_ERR(np_frame_err), .BUSY(np_busy)
    );

    always #5 clk = ~clk;

    // Downstream holding register fed directly by WORD/WORD_ENA.
    always @(posedge clk) begin
        if (rst) dreg <= '0;
        else if (word_ena) dreg <= word;
    end

    always @(negedge clk) begin
        if (word_ena) ena_cnt <= ena_cnt + 1;
        if (par_err) par_cnt <= par_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (np_word_ena) np_ena_cnt <= np_ena_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Idle for gap cycles, then present one bit; returns just after the edge that sampled it.
    task automatic drive_bit(input logic b, input logic f, input int gap);
        tick(gap);
        bit_valid = 1'b1;
        bit_data  = b;
        frame     = f;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        frame     = 1'b0;
    endtask

    task automatic test_reset();
        int e0, p0, f0;
        rst = 1'b1;
        tick(2);
        checks++;
        if (word !== 16'h0000) $display("FAIL reset_word: got %h want 0000", word);
        else passes++;
        checks++;
        if ({busy, word_ena, par_err, frame_err} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {busy, word_ena, par_err, frame_err});
        else passes++;
        checks++;
        if (np_word !== 16'h0000) $display("FAIL reset_np_word: got %h want 0000", np_word);
        else passes++;
        rst = 1'b0;
        tick(1);
        e0 = ena_cnt; p0 = par_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1, 1);
        checks++;
        if (busy !== 1'b1) $display("FAIL midframe_busy: got %b want 1", busy);
        else passes++;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || word !== 16'h0000)
            $display("FAIL midreset_state: busy=%b word=%h want 0 0000", busy, word);
        else passes++;
        tick(2);
        checks++;
        if ((ena_cnt - e0) != 0 || (par_cnt - p0) != 0 || (ferr_cnt - f0) != 0)
            $display("FAIL midreset_pulses: ena=%0d par=%0d ferr=%0d want 0 0 0",
                     ena_cnt - e0, par_cnt - p0, ferr_cnt - f0);
        else passes++;
    endtask

    task automatic test_good_word();
        logic [15:0] w;
        int e0;
        w  = 16'hA5A5;
        e0 = ena_cnt;
        for (int i = 0; i < 16; i++) drive_bit(w[15-i], 1'b1, 2);
        checks++;
        if (word_ena !== 1'b0 || busy !== 1'b1)
            $display("FAIL good_pre_parity: ena=%b busy=%b want 0 1", word_ena, busy);
        else passes++;
        drive_bit(1'b0, 1'b1, 2);
        checks++;
        if (word_ena !== 1'b1 || word !== 16'hA5A5)
            $display("FAIL good_strobe: ena=%b word=%h want 1 a5a5", word_ena, word);
        else passes++;
        tick(1);
        checks++;
        if (word_ena !== 1'b0 || busy !== 1'b0)
            $display("FAIL good_after: ena=%b busy=%b want 0 0", word_ena, busy);
        else passes++;
        checks++;
        if (dreg !== 16'hA5A5) $display("FAIL good_downstream: got %h want a5a5", dreg);
        else passes++;
        checks++;
        if ((ena_cnt - e0) != 1) $display("FAIL good_ena_count: got %0d want 1", ena_cnt - e0);
        else passes++;
    endtask

    task automatic test_parity_error();
        logic [15:0] w;
        int e0, p0;
        w  = 16'h0001;
        e0 = ena_cnt; p0 = par_cnt;
        for (int i = 0; i < 16; i++) drive_bit(w[15-i], 1'b1, 1);
        drive_bit(1'b0, 1'b1, 1);
        checks++;
        if (par_err !== 1'b1 || word_ena !== 1'b0 || busy !== 1'b0)
            $display("FAIL par_pulse: par=%b ena=%b busy=%b want 1 0 0", par_err, word_ena, busy);
        else passes++;
        tick(1);
        checks++;
        if (par_err !== 1'b0) $display("FAIL par_width: got %b want 0", par_err);
        else passes++;
        checks++;
        if (word !== 16'hA5A5 || dreg !== 16'hA5A5)
            $display("FAIL par_word_held: word=%h dreg=%h want a5a5", word, dreg);
        else passes++;
        checks++;
        if ((par_cnt - p0) != 1 || (ena_cnt - e0) != 0)
            $display("FAIL par_counts: par=%0d ena=%0d want 1 0", par_cnt - p0, ena_cnt - e0);
        else passes++;
    endtask

    task automatic test_frame_drop();
        int e0, f0;
        e0 = ena_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 8; i++) drive_bit(i[0], 1'b1, 1);
        drive_bit(1'b1, 1'b0, 1);
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0 || word_ena !== 1'b0)
            $display("FAIL drop_pulse: ferr=%b busy=%b ena=%b want 1 0 0",
                     frame_err, busy, word_ena);
        else passes++;
        tick(1);
        checks++;
        if (frame_err !== 1'b0 || (ferr_cnt - f0) != 1 || (ena_cnt - e0) != 0)
            $display("FAIL drop_after: ferr=%b nferr=%0d nena=%0d want 0 1 0",
                     frame_err, ferr_cnt - f0, ena_cnt - e0);
        else passes++;
        checks++;
        if (word !== 16'hA5A5) $display("FAIL drop_word_held: got %h want a5a5", word);
        else passes++;
    endtask

    task automatic test_timeout();
        logic [15:0] w;
        int e0, f0;
        f0 = ferr_cnt;
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b1, 1);
        tick(7);
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b1)
            $display("FAIL tmo_early: ferr=%b busy=%b want 0 1", frame_err, busy);
        else passes++;
        tick(1);
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL tmo_fire: ferr=%b busy=%b want 1 0", frame_err, busy);
        else passes++;
        tick(1);
        checks++;
        if ((ferr_cnt - f0) != 1) $display("FAIL tmo_count: got %0d want 1", ferr_cnt - f0);
        else passes++;
        // Stall of 7 idle cycles before bit 6; the bit arrives on the edge the timeout would hit.
        w  = 16'h1234;
        e0 = ena_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 16; i++) drive_bit(w[15-i], 1'b1, (i == 5) ? 7 : 1);
        drive_bit(1'b1, 1'b1, 1);
        checks++;
        if (word_ena !== 1'b1 || word !== 16'h1234)
            $display("FAIL tmo_bit_wins: ena=%b word=%h want 1 1234", word_ena, word);
        else passes++;
        tick(1);
        checks++;
        if ((ferr_cnt - f0) != 0 || (ena_cnt - e0) != 1)
            $display("FAIL tmo_no_err: nferr=%0d nena=%0d want 0 1", ferr_cnt - f0, ena_cnt - e0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n0 = np_ena_cnt;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) drive_bit(1'b1, 1'b1, 1);
            checks++;
            if (np_word_ena !== 1'b1 || np_word !== 16'hFFFF)
                $display("FAIL b2b_strobe%0d: ena=%b word=%h want 1 ffff", k, np_word_ena, np_word);
            else passes++;
        end
        tick(1);
        checks++;
        if (np_word_ena !== 1'b0 || np_busy !== 1'b0 || np_frame_err !== 1'b0)
            $display("FAIL b2b_after: ena=%b busy=%b ferr=%b want 0 0 0",
                     np_word_ena, np_busy, np_frame_err);
        else passes++;
        checks++;
        if ((np_ena_cnt - n0) != 2) $display("FAIL b2b_count: got %0d want 2", np_ena_cnt - n0);
        else passes++;
    endtask

    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        frame     = 1'b0;
        test_reset();
        test_good_word();
        test_parity_error();
        test_frame_drop();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
